// File: rtl/mult_arbiter.sv
// Round-robin arbiter that shares one multi-cycle start/done multiplier among NUM_REQ requesters.
// One operation is in flight at a time: grant in IDLE, start pulse, wait for done, return product to owner.
module mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_mcand,
  input  logic [NUM_REQ*WIDTH-1:0]   req_mplier,
  input  logic [NUM_REQ-1:0]         req_cancel,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [2*WIDTH-1:0]         resp_product,
  output logic                       mult_start,
  output logic [WIDTH-1:0]           mult_mcand,
  output logic [WIDTH-1:0]           mult_mplier,
  input  logic [2*WIDTH-1:0]         mult_product,
  input  logic                       mult_done,
  output logic                       busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic             drop;
  logic [PTR_W-1:0] grant_idx;
  logic             grant_found;
  logic [PTR_W:0]   cand;

  // Round-robin search: first valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(NUM_REQ))
        cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!grant_found && req_valid[cand[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mult_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is gated by reset so every output reads zero while reset is held.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    mult_start = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE:  if (reset && grant_found) req_ready[grant_idx] = 1'b1;
      ISSUE: begin
        mult_start = 1'b1;
        busy       = 1'b1;
      end
      WAIT:  busy = 1'b1;
      RESP: begin
        busy              = 1'b1;
        resp_valid[owner] = ~drop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: datapath registers are plain flops (not a memory), so they are reset to a known zero.
    if (!reset) begin
      ptr          <= '0;
      owner        <= '0;
      drop         <= 1'b0;
      mult_mcand   <= '0;
      mult_mplier  <= '0;
      resp_product <= '0;
    end else begin
      case (state)
        IDLE: if (grant_found) begin
          mult_mcand  <= req_mcand[grant_idx*WIDTH +: WIDTH];
          mult_mplier <= req_mplier[grant_idx*WIDTH +: WIDTH];
          owner       <= grant_idx;
          drop        <= 1'b0;
          ptr         <= (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        end
        ISSUE: if (req_cancel[owner]) drop <= 1'b1;
        WAIT: begin
          if (req_cancel[owner]) drop <= 1'b1;
          // The multiplier cannot be aborted, so the product is captured even when dropped.
          if (mult_done) resp_product <= mult_product;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed and randomized bench for mult_arbiter with a latency-programmable multiplier model
// and a round-robin reference kept as a simple pointer plus modulo search.
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*W-1:0]   req_mcand = '0;
  logic [N*W-1:0]   req_mplier = '0;
  logic [N-1:0]     req_cancel = '0;
  logic [N-1:0]     req_ready;
  logic [N-1:0]     resp_valid;
  logic [2*W-1:0]   resp_product;
  logic             mult_start;
  logic [W-1:0]     mult_mcand;
  logic [W-1:0]     mult_mplier;
  logic [2*W-1:0]   mult_product;
  logic             mult_done;
  logic             busy;

  int               vectors = 0;
  int               miscompares = 0;
  int               exp_ptr = 0;
  int               mult_lat = 8;
  bit               auto_mult = 1'b1;
  logic             model_done = 1'b0;
  logic [2*W-1:0]   model_product = '0;
  logic [2*W-1:0]   model_p;
  logic             man_done = 1'b0;
  logic [2*W-1:0]   man_product = '0;
  logic [W-1:0]     op_mc [N];
  logic [W-1:0]     op_mp [N];

  assign mult_done    = auto_mult ? model_done : man_done;
  assign mult_product = auto_mult ? model_product : man_product;

  always #5 clock = ~clock;

  mult_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_mcand    (req_mcand),
    .req_mplier   (req_mplier),
    .req_cancel   (req_cancel),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .mult_start   (mult_start),
    .mult_mcand   (mult_mcand),
    .mult_mplier  (mult_mplier),
    .mult_product (mult_product),
    .mult_done    (mult_done),
    .busy         (busy)
  );

  // Multiplier model: start seen at the edge closing cycle s, done high during cycle s+L.
  always @(posedge clock) begin
    if (auto_mult && mult_start) begin
      model_p = {32'b0, mult_mcand} * {32'b0, mult_mplier};
      repeat (mult_lat - 1) @(posedge clock);
      #1;
      model_product = model_p;
      model_done    = 1'b1;
      @(posedge clock);
      #1 model_done = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_grant(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++) begin
      if (mask[(exp_ptr + i) % N]) return (exp_ptr + i) % N;
    end
    return 0;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_mcand[i*W +: W]  = op_mc[i];
      req_mplier[i*W +: W] = op_mp[i];
    end
  endtask

  // One complete transaction starting in IDLE; cancel (if any) is pulsed in cycle cancel_at.
  task automatic run_op(input string tag, input logic [N-1:0] mask, input int lat,
                        input bit cancel_own, input logic [N-1:0] cancel_oth, input int cancel_at);
    int             k;
    logic [N-1:0]   onehot;
    logic [N-1:0]   cmask;
    logic [63:0]    prod;
    bit             early;
    k      = exp_grant(mask);
    onehot = N'(1 << k);
    prod   = {32'b0, op_mc[k]} * {32'b0, op_mp[k]};
    cmask  = (cancel_own ? onehot : '0) | (cancel_oth & ~onehot);
    mult_lat = lat;
    drive_ops();
    req_valid = mask;
    #1;
    check({tag, " grant"}, req_ready, onehot);
    check({tag, " idle busy"}, busy, 0);
    tick();
    req_valid  = mask & ~onehot;
    req_cancel = (cancel_at == 1) ? cmask : '0;
    #1;
    check({tag, " start"}, mult_start, 1);
    check({tag, " mcand"}, mult_mcand, op_mc[k]);
    check({tag, " mplier"}, mult_mplier, op_mp[k]);
    check({tag, " issue ready"}, req_ready, 0);
    tick();
    req_valid  = mask;
    req_cancel = (cancel_at == 2) ? cmask : '0;
    #1;
    check({tag, " wait ready"}, req_ready, 0);
    early = 1'b0;
    for (int c = 2; c < 2 + lat; c++) begin
      if (resp_valid !== '0 || mult_start !== 1'b0 || busy !== 1'b1) early = 1'b1;
      tick();
      req_cancel = '0;
    end
    check({tag, " wait quiet"}, early, 0);
    check({tag, " resp_valid"}, resp_valid, cancel_own ? '0 : onehot);
    check({tag, " product"}, resp_product, prod);
    check({tag, " resp ready"}, req_ready, 0);
    tick();
    check({tag, " back idle"}, busy, 0);
    check({tag, " resp pulse"}, resp_valid, 0);
    req_valid = '0;
    exp_ptr = (k + 1) % N;
  endtask

  initial begin
    logic [N-1:0] mask;
    logic [63:0]  prod;
    bit           flag;
    int           k;

    for (int i = 0; i < N; i++) begin
      op_mc[i] = '0;
      op_mp[i] = '0;
    end

    #12;
    check("rst ready", req_ready, 0);
    check("rst resp_valid", resp_valid, 0);
    check("rst busy", busy, 0);
    check("rst start", mult_start, 0);
    check("rst mcand", mult_mcand, 0);
    check("rst product", resp_product, 0);
    tick();
    reset = 1'b1;
    tick();

    // All four continuously valid: grants rotate 0..3, products i+1 squared.
    for (int i = 0; i < N; i++) begin
      op_mc[i] = W'(i + 1);
      op_mp[i] = W'(i + 1);
    end
    for (int i = 0; i < N; i++) run_op("rr", 4'b1111, 8, 1'b0, '0, 1);

    // Single request on 2 with latency 8.
    op_mc[2] = 32'h0000_1234;
    op_mp[2] = 32'h0000_1234;
    run_op("single", 4'b0100, 8, 1'b0, '0, 1);
    check("single const", resp_product, 64'h14B_5A90);

    // Wrap-around from ptr 3 with requests 1 and 3, then confirm ptr ended at 2.
    for (int i = 0; i < N; i++) begin
      op_mc[i] = $urandom;
      op_mp[i] = $urandom;
    end
    run_op("wrap3", 4'b1010, 5, 1'b0, '0, 1);
    run_op("wrap1", 4'b1010, 5, 1'b0, '0, 1);
    run_op("ptr2", 4'b0101, 5, 1'b0, '0, 1);

    // Owner cancel in WAIT with a simultaneous non-owner cancel, then non-owner cancel alone.
    run_op("cancel", 4'b0001, 4, 1'b1, 4'b0010, 2);
    run_op("oth_cancel", 4'b0001, 4, 1'b0, 4'b0010, 2);

    // Stale done during ISSUE must be ignored; a later done completes the op.
    auto_mult = 1'b0;
    op_mc[1] = $urandom;
    op_mp[1] = $urandom;
    drive_ops();
    mask = 4'b0010;
    k    = exp_grant(mask);
    prod = {32'b0, op_mc[1]} * {32'b0, op_mp[1]};
    req_valid = mask;
    #1;
    check("stale grant", req_ready, N'(1 << k));
    tick();
    req_valid   = '0;
    man_done    = 1'b1;
    man_product = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    check("stale start", mult_start, 1);
    tick();
    man_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stale hold", {busy, resp_valid}, {1'b1, 4'b0000});
      tick();
    end
    man_done    = 1'b1;
    man_product = prod;
    tick();
    man_done = 1'b0;
    #1;
    check("stale resp", resp_valid, N'(1 << k));
    check("stale product", resp_product, prod);
    tick();
    check("stale idle", busy, 0);
    exp_ptr = (k + 1) % N;
    auto_mult = 1'b1;

    // Randomized traffic against the pointer/modulo reference.
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < N; i++) begin
        op_mc[i] = $urandom;
        op_mp[i] = $urandom;
      end
      mask = N'($urandom_range(1, 15));
      run_op("rand", mask, int'($urandom_range(1, 6)), ($urandom_range(0, 3) == 0),
             N'($urandom), int'($urandom_range(1, 2)));
    end

    // Asynchronous reset in the middle of WAIT.
    op_mc[3] = $urandom;
    op_mp[3] = $urandom;
    drive_ops();
    mult_lat  = 8;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    req_valid = 4'b0110;
    #1;
    check("mid rst busy", busy, 0);
    check("mid rst start", mult_start, 0);
    check("mid rst mcand", {mult_mcand, mult_mplier}, 0);
    check("mid rst product", resp_product, 0);
    check("mid rst ready", req_ready, 0);
    req_valid = '0;
    tick();
    tick();
    reset   = 1'b1;
    exp_ptr = 0;
    flag    = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (resp_valid !== '0 || busy !== 1'b0) flag = 1'b1;
      tick();
    end
    check("post rst quiet", flag, 0);
    op_mc[1] = $urandom;
    op_mp[1] = $urandom;
    run_op("post_rst", 4'b1010, 3, 1'b0, '0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle `mult` unit (start/done handshake, 32x32 -> 64) between up to `NUM_REQ` requesters, e.g. several ISR engines. It accepts one operand pair at a time, pulses the multiplier start, waits for done and returns the product to the owning requester. It sits between the requesters and the single `mult` instance, and owns that instance's `start`, `mcand` and `mplier` inputs.

## Interface

- `NUM_REQ`, default 4: number of requesters (2..16).
- `WIDTH`, default 32: operand width. The product is 2*WIDTH.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has an operand pair pending.
- `req_mcand` in NUM_REQ*WIDTH: slice i is requester i's multiplicand.
- `req_mplier` in NUM_REQ*WIDTH: slice i is requester i's multiplier.
- `req_cancel` in NUM_REQ: requester i abandons its in-flight operation.
- `req_ready` out NUM_REQ: grant. At most one bit is set. Transfer occurs when `req_valid[i] & req_ready[i]`.
- `resp_valid` out NUM_REQ: one-cycle pulse to the owner when its product is valid.
- `resp_product` out 2*WIDTH: shared result bus.
- `mult_start` out 1: one-cycle start pulse to `mult`.
- `mult_mcand` out WIDTH: latched operand to `mult`.
- `mult_mplier` out WIDTH: latched operand to `mult`.
- `mult_product` in 2*WIDTH: product from `mult`.
- `mult_done` in 1: done from `mult`.
- `busy` out 1: high when the state is not IDLE.

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Search `req_valid` starting at pointer `ptr`, ascending, wrapping modulo NUM_REQ.
  - The first set bit k gets `req_ready[k]=1`. This is combinational, in IDLE only.
  - On transfer, latch mcand/mplier slice k and owner=k, clear `drop`, set `ptr <= (k+1) mod NUM_REQ`, and go to ISSUE.
  - With no valid request, stay in IDLE and leave `ptr` unchanged.
- ISSUE
  - `mult_start=1` for exactly this cycle. Go to WAIT.
  - `mult_done` seen in this cycle is stale and ignored.
- WAIT
  - Hold `mult_mcand`/`mult_mplier` stable.
  - On `mult_done`, latch `mult_product` into `resp_product` and go to RESP.
  - There is no timeout.
- RESP
  - `resp_valid[owner] = ~drop` for this cycle. Go to IDLE.
  - No grant is issued in RESP.
- Cancel
  - `req_cancel[owner]` during ISSUE or WAIT sets `drop`.
  - The multiplication still runs to `mult_done`, because `mult` cannot be aborted.
  - `resp_product` is still updated, but `resp_valid` is suppressed.
  - Cancel from a non-owner, or in IDLE/RESP, is ignored.
- `req_valid` dropping without an accepted transfer is legal and has no effect.
- Requesters must hold `req_valid` and their operands until they see `req_ready`.
- `req_ready` is never asserted outside IDLE. This includes a requester that re-requests while its own operation is in flight.
- `resp_product` holds its last value until the next WAIT->RESP latch.
- Arithmetic is performed entirely by `mult`. The block never modifies operands or the product.

## Timing

- Reset (`reset` low, asynchronous):
  - State goes to IDLE; `ptr=0`; `drop=0`; owner=0.
  - `mult_start`, `resp_valid`, `busy` = 0.
  - `mult_mcand`, `mult_mplier`, `resp_product` = 0.
  - `req_ready` follows IDLE logic once reset is released.
- Reset asserted mid-operation aborts the operation. No `resp_valid` is produced. The `mult` is reset by its own reset, which is outside this block.
- With the grant at cycle 0:
  - `mult_start` is at cycle 1.
  - `mult_done` arrives at cycle 1+L, where L is the `mult` latency.
  - `resp_valid` is at cycle 2+L.
  - The earliest next grant is at cycle 3+L.
  - Throughput is one operation per L+3 cycles.
- If `mult_done` arrives in the first WAIT cycle, the block still transitions normally (RESP on the next cycle).
- `busy` is registered from state: high from cycle 1 through cycle 2+L.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. Each requester waits at most NUM_REQ-1 other operations.

## Test plan

- Single request, NUM_REQ=4: req 2 valid, mcand=0x0000_1234, mplier=0x0000_1234, mult model L=8.
  - `req_ready[2]` at cycle 0, `mult_start` at cycle 1.
  - `resp_valid[2]` at cycle 10 with `resp_product=0x14B5A90`.
  - `ptr=3`.
- All four valid from reset, each with mcand=mplier=i+1.
  - Grant order 0,1,2,3.
  - Responses 1, 4, 9, 16 on their owners.
  - Each grant L+3 cycles apart.
- Wrap-around: `ptr=3`, requests 1 and 3 valid.
  - Grant 3 first, then 1; `ptr` ends at 2.
- Cancel: owner 0 asserts `req_cancel` in the WAIT cycle after the grant.
  - `mult_done` still consumed and `resp_product` updated.
  - No `resp_valid`; IDLE on the next cycle.
  - A cancel pulse from requester 1 at the same time has no effect.
- Stale and early done: `mult_done` forced high during ISSUE and low afterward.
  - Block stays in WAIT.
  - A later `mult_done` produces the response.
- Reset mid-WAIT: pull `reset` low asynchronously between clock edges.
  - All outputs are 0 immediately.
  - No `resp_valid` after release.
  - The first grant after reset goes to the lowest valid index.
